// File: rtl/bits_to_bytes_seq.sv
// Sequential bit-to-byte packer: gathers IN_W-bit beats LSB-first into bytes
// and streams them out with valid/ready handshakes, one job of MSG_BITS per start.
module bits_to_bytes_seq #(
  parameter int MSG_BITS = 256,
  parameter int IN_W     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_bits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_byte,
  output logic            out_last
);

  localparam int MSG_BYTES = MSG_BITS / 8;
  localparam int CNT_W     = $clog2(MSG_BYTES + 1);
  localparam logic [2:0]       LAST_BITCNT = 3'(8 - IN_W);
  localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(MSG_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       acc;
  logic [2:0]       bitcnt;
  logic [CNT_W-1:0] bytecnt;
  logic             completing;
  logic             last_byte;
  logic             in_fire;
  logic             out_fire;
  logic [7:0]       merged;

  // Accumulator bits above bitcnt are always clear, so OR-ing places the beat.
  assign completing = (bitcnt == LAST_BITCNT);
  assign last_byte  = (bytecnt == LAST_BYTE);
  assign merged     = acc | (8'(in_bits) << bitcnt);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        // A completing beat may only enter if the output slot is free or draining now.
        in_ready = !completing || !out_valid || out_ready;
        if (in_valid && in_ready && completing && last_byte) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_fire) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      bitcnt    <= '0;
      bytecnt   <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            bitcnt  <= '0;
            bytecnt <= '0;
          end
        end
        RUN: begin
          if (in_fire && completing) begin
            out_byte  <= merged;
            out_valid <= 1'b1;
            out_last  <= last_byte;
            acc       <= '0;
            bitcnt    <= '0;
            bytecnt   <= bytecnt + CNT_W'(1);
          end else begin
            if (in_fire) begin
              acc    <= merged;
              bitcnt <= bitcnt + 3'(IN_W);
            end
            if (out_fire) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bits_to_bytes_seq.sv
// Directed self-checking bench for bits_to_bytes_seq using three parameterisations
// (IN_W=1/8 bits, IN_W=4/32 bits, IN_W=8/256 bits).
module tb_bits_to_bytes_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  logic       a_start, a_busy, a_done, a_in_valid, a_in_ready;
  logic       a_out_valid, a_out_ready, a_out_last;
  logic [0:0] a_in_bits;
  logic [7:0] a_out_byte;

  logic       b_start, b_busy, b_done, b_in_valid, b_in_ready;
  logic       b_out_valid, b_out_ready, b_out_last;
  logic [3:0] b_in_bits;
  logic [7:0] b_out_byte;

  logic       c_start, c_busy, c_done, c_in_valid, c_in_ready;
  logic       c_out_valid, c_out_ready, c_out_last;
  logic [7:0] c_in_bits;
  logic [7:0] c_out_byte;

  logic [7:0]  a_pattern;
  logic [31:0] msg;
  int          bi, oi;
  logic        done_seen;

  bits_to_bytes_seq #(.MSG_BITS(8), .IN_W(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bits(a_in_bits),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_byte(a_out_byte),
    .out_last(a_out_last)
  );

  bits_to_bytes_seq #(.MSG_BITS(32), .IN_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bits(b_in_bits),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_byte(b_out_byte),
    .out_last(b_out_last)
  );

  bits_to_bytes_seq #(.MSG_BITS(256), .IN_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .busy(c_busy), .done(c_done),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bits(c_in_bits),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_byte(c_out_byte),
    .out_last(c_out_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full 32-byte job on the 8-bit instance; a stray start is raised at beat 'glitch'.
  task automatic run_job8(input logic [7:0] base, input int glitch);
    c_out_ready = 1'b1;
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      c_in_valid = 1'b1;
      c_in_bits  = 8'(base + k);
      c_start    = (k == glitch);
      @(negedge clk);
      check_output("c_in_ready_run", c_in_ready, 1);
      check_output("c_busy_run", c_busy, 1);
      step();
      check_output("c_out_valid", c_out_valid, 1);
      check_output("c_out_byte", c_out_byte, 8'(base + k));
      check_output("c_out_last", c_out_last, (k == 31));
      check_output("c_done_run", c_done, 0);
    end
    c_in_valid = 1'b0;
    c_start    = 1'b0;
    @(negedge clk);
    check_output("c_in_ready_drain", c_in_ready, 0);
    check_output("c_busy_drain", c_busy, 1);
    step();
    check_output("c_done_pulse", c_done, 1);
    check_output("c_busy_done", c_busy, 0);
    check_output("c_out_valid_done", c_out_valid, 0);
    step();
    check_output("c_done_clear", c_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_in_valid = 0; a_in_bits = 0; a_out_ready = 0;
    b_start = 0; b_in_valid = 0; b_in_bits = 0; b_out_ready = 0;
    c_start = 0; c_in_valid = 0; c_in_bits = 0; c_out_ready = 0;
    step();
    step();
    check_output("rst_busy", a_busy, 0);
    check_output("rst_done", a_done, 0);
    check_output("rst_out_valid", a_out_valid, 0);
    check_output("rst_out_byte", a_out_byte, 0);
    check_output("rst_out_last", a_out_last, 0);
    check_output("rst_in_ready", a_in_ready, 0);
    check_output("rst_b_in_ready", b_in_ready, 0);
    rst_n = 1'b1;

    // Single byte, 1-bit beats: bits 1,0,1,0,0,0,0,0 pack to 0x05.
    a_pattern   = 8'b0000_0101;
    a_out_ready = 1'b1;
    a_start     = 1'b1;
    step();
    a_start = 1'b0;
    check_output("a_busy_start", a_busy, 1);
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_bits  = a_pattern[i];
      @(negedge clk);
      check_output("a_in_ready", a_in_ready, 1);
      check_output("a_out_valid_early", a_out_valid, 0);
      step();
    end
    a_in_valid = 1'b0;
    check_output("a_out_valid", a_out_valid, 1);
    check_output("a_out_byte", a_out_byte, 8'h05);
    check_output("a_out_last", a_out_last, 1);
    check_output("a_done_early", a_done, 0);
    check_output("a_busy_drain", a_busy, 1);
    step();
    check_output("a_done_pulse", a_done, 1);
    check_output("a_out_valid_done", a_out_valid, 0);
    check_output("a_busy_done", a_busy, 0);
    step();
    check_output("a_done_clear", a_done, 0);

    // Back-pressure on 4-bit beats: bytes 0x5A, 0xC3, 0x21, 0x84.
    b_out_ready = 1'b0;
    b_start     = 1'b1;
    step();
    b_start    = 1'b0;
    b_in_valid = 1'b1;
    b_in_bits  = 4'hA;
    step();
    b_in_bits = 4'h5;
    step();
    check_output("b_first_valid", b_out_valid, 1);
    check_output("b_first_byte", b_out_byte, 8'h5A);
    check_output("b_first_last", b_out_last, 0);
    b_in_bits = 4'h3;
    @(negedge clk);
    check_output("b_ready_noncomplete", b_in_ready, 1);
    step();
    b_in_bits = 4'hC;
    @(negedge clk);
    check_output("b_ready_blocked", b_in_ready, 0);
    step();
    check_output("b_hold_valid", b_out_valid, 1);
    check_output("b_hold_byte", b_out_byte, 8'h5A);
    @(negedge clk);
    check_output("b_ready_blocked2", b_in_ready, 0);
    step();
    check_output("b_hold_byte2", b_out_byte, 8'h5A);
    check_output("b_hold_last", b_out_last, 0);
    b_out_ready = 1'b1;
    @(negedge clk);
    check_output("b_ready_resume", b_in_ready, 1);
    step();
    check_output("b_replace_valid", b_out_valid, 1);
    check_output("b_replace_byte", b_out_byte, 8'hC3);
    b_in_bits = 4'h1;
    step();
    check_output("b_drop_valid", b_out_valid, 0);
    b_in_bits = 4'h2;
    step();
    check_output("b_third_valid", b_out_valid, 1);
    check_output("b_third_byte", b_out_byte, 8'h21);
    b_in_bits = 4'h4;
    step();
    check_output("b_drop_valid2", b_out_valid, 0);
    b_in_bits   = 4'h8;
    b_out_ready = 1'b0;
    step();
    b_in_valid = 1'b0;
    check_output("b_last_byte", b_out_byte, 8'h84);
    check_output("b_last_flag", b_out_last, 1);
    check_output("b_busy_drain", b_busy, 1);
    step();
    check_output("b_drain_hold", b_out_valid, 1);
    check_output("b_drain_no_done", b_done, 0);
    check_output("b_drain_byte", b_out_byte, 8'h84);
    b_out_ready = 1'b1;
    step();
    check_output("b_done_pulse", b_done, 1);
    check_output("b_done_out_valid", b_out_valid, 0);
    step();
    check_output("b_done_clear", b_done, 0);

    // Random valid/ready back-pressure, compared against direct bit-slice packing.
    for (int job = 0; job < 100; job++) begin
      msg     = $urandom();
      b_start = 1'b1;
      step();
      b_start   = 1'b0;
      bi        = 0;
      oi        = 0;
      done_seen = 1'b0;
      for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
        b_in_valid  = (bi < 8) && ($urandom_range(0, 2) != 0);
        b_in_bits   = msg[(bi % 8)*4 +: 4];
        b_out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (b_done) done_seen = 1'b1;
        if (b_in_valid && b_in_ready) bi++;
        if (b_out_valid && b_out_ready) begin
          check_output("rnd_byte", b_out_byte, msg[(oi % 4)*8 +: 8]);
          check_output("rnd_last", b_out_last, ((oi % 4) == 3));
          oi++;
        end
        step();
      end
      b_in_valid = 1'b0;
      check_output("rnd_job_done", done_seen, 1);
      check_output("rnd_byte_count", oi, 4);
    end
    b_out_ready = 1'b0;

    // 32 bytes back-to-back with a stray start mid-job.
    run_job8(8'h00, 10);

    // Reset after byte 10 aborts the job; the next job must be clean.
    c_out_ready = 1'b1;
    c_start     = 1'b1;
    step();
    c_start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      c_in_valid = 1'b1;
      c_in_bits  = 8'(8'h80 + k);
      step();
      check_output("c_pre_reset_byte", c_out_byte, 8'(8'h80 + k));
    end
    rst_n = 1'b0;
    step();
    check_output("c_abort_valid", c_out_valid, 0);
    check_output("c_abort_busy", c_busy, 0);
    check_output("c_abort_done", c_done, 0);
    check_output("c_abort_byte", c_out_byte, 0);
    check_output("c_abort_last", c_out_last, 0);
    @(negedge clk);
    check_output("c_abort_ready", c_in_ready, 0);
    rst_n      = 1'b1;
    c_in_valid = 1'b0;
    step();
    check_output("c_abort_no_done", c_done, 0);
    run_job8(8'h40, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
